mp_deq_serializer: RTL and testbench

MP_DEQ_SERIALIZER -- requirements
Module: mp_deq_serializer

---
 rtl/mp_deq_serializer_pkg.sv | 10 +
 rtl/mp_deq_serializer_lane_prefix_cnt.sv | 25 ++
 rtl/mp_deq_serializer.sv | 83 ++++++++
 tb/tb_mp_deq_serializer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mp_deq_serializer_pkg.sv
// Shared helpers for the multi-port dequeue serializer.
// Width helpers only; every width itself is still derived inside the modules that use it.
package mp_deq_serializer_pkg;

    // A read index must be at least one bit wide, even for a single-entry buffer.
    function automatic int idx_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/mp_deq_serializer_lane_prefix_cnt.sv
// Finds the contiguous run of valid lanes starting at lane 0 and counts it.
// Lanes above the first non-valid lane are never taken, which keeps the FIFO order intact.
module lane_prefix_cnt #(
    parameter int DEQ_WIDTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic [DEQ_WIDTH-1:0] vld,
    output logic [DEQ_WIDTH-1:0] take,
    output logic [CNT_W-1:0]     n
);

    logic run;

    always_comb begin
        run  = 1'b1;
        take = '0;
        n    = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            run     = run & vld[i];
            take[i] = run;
            n       = n + CNT_W'(run);
        end
    end

endmodule

// File: rtl/mp_deq_serializer.sv
// Takes a bundle of up to DEQ_WIDTH entries from a multi-port FIFO and emits it one entry per cycle.
// The next bundle is loaded on the same edge that the last entry of the current one is accepted.
module mp_deq_serializer
    import mp_deq_serializer_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 3,
    parameter int DEQ_WIDTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DEQ_WIDTH-1:0]               deq_vld_i,
    input  logic [PAYLOAD_WIDTH*DEQ_WIDTH-1:0] deq_payload_i,
    output logic [DEQ_WIDTH-1:0]               deq_rdy_o,
    output logic                               out_vld_o,
    output logic [PAYLOAD_WIDTH-1:0]           out_payload_o,
    input  logic                               out_rdy_i,
    input  logic                               flush_i
);

    localparam int CNT_W = $clog2(DEQ_WIDTH + 1);
    localparam int IDX_W = idx_width(DEQ_WIDTH);

    logic [PAYLOAD_WIDTH-1:0] buffer [DEQ_WIDTH];
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         rd_idx;
    logic [CNT_W-1:0]         remaining;
    logic [DEQ_WIDTH-1:0]     take;
    logic [CNT_W-1:0]         n;
    logic                     load_en;
    logic                     load_fire;
    logic                     advance;

    lane_prefix_cnt #(
        .DEQ_WIDTH (DEQ_WIDTH),
        .CNT_W     (CNT_W)
    ) u_lane_prefix_cnt (
        .vld  (deq_vld_i),
        .take (take),
        .n    (n)
    );

    assign remaining = cnt - CNT_W'(rd_idx);

    // Reload when empty, or when the last held entry leaves this very cycle.
    assign load_en   = !flush_i && ((remaining == '0) ||
                                    ((remaining == CNT_W'(1)) && out_rdy_i));
    assign load_fire = load_en && (n != '0);
    assign advance   = out_vld_o && out_rdy_i;

    assign deq_rdy_o     = load_en ? take : '0;
    assign out_vld_o     = (remaining != '0);
    assign out_payload_o = buffer[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rd_idx <= '0;
        end else if (flush_i) begin
            cnt    <= '0;
            rd_idx <= '0;
        end else if (load_fire) begin
            cnt    <= n;
            rd_idx <= '0;
        end else if (advance) begin
            if (remaining > CNT_W'(1)) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end else begin
                cnt    <= '0;
                rd_idx <= '0;
            end
        end
    end

    // Taken lanes are always 0..n-1, so slot k simply mirrors lane k; slots at or above n are don't-care.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int k = 0; k < DEQ_WIDTH; k++) begin
                buffer[k] <= deq_payload_i[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mp_deq_serializer.sv
// Scoreboard bench for mp_deq_serializer with the default 4 lanes of 3-bit payload.
// Taken lanes are queued when deq_rdy is expected, and popped and compared on each accepted output.
module tb_mp_deq_serializer;

    localparam int PW = 3;
    localparam int DW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    deq_vld_i = '0;
    logic [PW*DW-1:0] deq_payload_i = '0;
    logic [DW-1:0]    deq_rdy_o;
    logic             out_vld_o;
    logic [PW-1:0]    out_payload_o;
    logic             out_rdy_i = 1'b0;
    logic             flush_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] sb_q [$];
    int            mrem = 0;
    logic          stalled_prev = 1'b0;
    logic [PW-1:0] prev_pl = '0;

    mp_deq_serializer #(.PAYLOAD_WIDTH(PW), .DEQ_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .deq_vld_i     (deq_vld_i),
        .deq_payload_i (deq_payload_i),
        .deq_rdy_o     (deq_rdy_o),
        .out_vld_o     (out_vld_o),
        .out_payload_o (out_payload_o),
        .out_rdy_i     (out_rdy_i),
        .flush_i       (flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] prefix_take(input logic [DW-1:0] v);
        logic [DW-1:0] t;
        t = '0;
        for (int i = 0; i < DW; i++) begin
            if (v[i] && (i == 0 || t[i-1])) t[i] = 1'b1;
        end
        return t;
    endfunction

    // One clock: drive inputs, check everything visible this cycle, update the model, advance.
    task automatic cycle(input logic [DW-1:0] vld, input logic [PW*DW-1:0] pl,
                         input logic ordy, input logic fl);
        logic [DW-1:0] t;
        logic [DW-1:0] exp_rdy;
        logic          ld;
        int            nt;
        logic [PW-1:0] e;
        deq_vld_i     = vld;
        deq_payload_i = pl;
        out_rdy_i     = ordy;
        flush_i       = fl;
        #1;
        t  = prefix_take(vld);
        nt = $countones(t);
        ld = !fl && (mrem == 0 || (mrem == 1 && ordy));
        exp_rdy = ld ? t : '0;
        chk("out_vld", 32'(out_vld_o), 32'(mrem != 0));
        chk("deq_rdy", 32'(deq_rdy_o), 32'(exp_rdy));
        if (stalled_prev && mrem != 0)
            chk("stall_hold", 32'(out_payload_o), 32'(prev_pl));
        if (!fl && mrem != 0 && ordy) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("payload", 32'(out_payload_o), 32'(e));
            end
        end
        stalled_prev = !fl && mrem != 0 && !ordy;
        prev_pl      = out_payload_o;
        if (fl) begin
            sb_q.delete();
            mrem = 0;
        end else if (ld && nt > 0) begin
            for (int i = 0; i < nt; i++) sb_q.push_back(pl[i*PW +: PW]);
            mrem = nt;
        end else if (mrem > 0 && ordy) begin
            mrem = mrem - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [PW*DW-1:0] rnd_pl();
        logic [PW*DW-1:0] p;
        for (int i = 0; i < DW; i++) p[i*PW +: PW] = PW'($urandom_range(0, (1 << PW) - 1));
        return p;
    endfunction

    task automatic drain();
        for (int i = 0; i < DW + 1; i++) cycle('0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset: output idle, lanes still offered as if empty.
        deq_vld_i = 4'b1111;
        #2;
        chk("rst_out_vld", 32'(out_vld_o), 32'd0);
        chk("rst_deq_rdy", 32'(deq_rdy_o), 32'hf);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full bundle 1,2,3,4 streamed back to back.
        cycle(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b0);
        drain();

        // Gap in valid mask: only lanes 0 and 1 taken.
        cycle(4'b1011, rnd_pl(), 1'b1, 1'b0);
        drain();

        // Two-lane bundles continuously: no bubbles across bundle boundaries.
        for (int i = 0; i < 10; i++) cycle(4'b0011, rnd_pl(), 1'b1, 1'b0);
        drain();

        // Stall with two entries left.
        cycle(4'b1111, rnd_pl(), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b1111, rnd_pl(), 1'b0, 1'b0);
        drain();

        // Flush with three entries left and a full bundle offered.
        cycle(4'b1111, rnd_pl(), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        cycle(4'b1111, rnd_pl(), 1'b1, 1'b1);
        cycle('0, '0, 1'b1, 1'b0);
        drain();

        // Asynchronous reset between edges while a bundle is draining.
        cycle(4'b1111, rnd_pl(), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        deq_vld_i = '0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vld", 32'(out_vld_o), 32'd0);
        sb_q.delete();
        mrem = 0;
        stalled_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0111, rnd_pl(), 1'b1, 1'b0);
        drain();

        // Random traffic with occasional stalls and flushes.
        for (int i = 0; i < 300; i++) begin
            cycle(DW'($urandom_range(0, 15)), rnd_pl(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
        end
        drain();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
